// File: rtl/add_sub_pkg.sv
// ============================================================================
// Module      : add_sub_pkg
// Description : Shared width and mode constants for the SAP1 ALU adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package add_sub_pkg;

  localparam int   ADD_SUB_WIDTH = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage : add_sub_pkg

`default_nettype wire

// File: rtl/add_sub_full_adder.sv
// ============================================================================
// Module      : add_sub_full_adder
// Description : One-bit full adder, a single stage of the ripple-carry chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_sub_full_adder (
  output logic s,
  output logic co,
  input  logic x,
  input  logic y,
  input  logic ci
);

  logic half_sum;

  assign half_sum = x ^ y;
  assign s        = half_sum ^ ci;
  assign co       = (x & y) | (ci & half_sum);

endmodule : add_sub_full_adder

`default_nettype wire

// File: rtl/add_sub_4_bit.sv
// ============================================================================
// Module      : add_sub_4_bit
// Description : Registered two's-complement adder/subtractor (M=0 add, M=1 sub).
//               Define ADD_SUB_4_BIT_FLAGS_EN to add the V and Z flag outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_sub_4_bit
  import add_sub_pkg::*;
#(
  parameter int WIDTH = ADD_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic [WIDTH-1:0] S,
  output logic             C
`ifdef ADD_SUB_4_BIT_FLAGS_EN
  ,
  output logic             V,
  output logic             Z
`endif
);

  logic             sub_mode;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_d, c_q;

  // Subtraction is A + ~B + 1: invert B and inject the +1 as the stage-0 carry.
  assign sub_mode = (M == MODE_SUB);
  assign bx       = B ^ {WIDTH{sub_mode}};
  assign carry[0] = sub_mode;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    add_sub_full_adder u_fa (
      .s  (sum[i]),
      .co (carry[i+1]),
      .x  (A[i]),
      .y  (bx[i]),
      .ci (carry[i])
    );
  end

  assign s_d = sum;
  assign c_d = carry[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign S = s_q;
  assign C = c_q;

`ifdef ADD_SUB_4_BIT_FLAGS_EN
  logic v_d, v_q;
  logic z_d, z_q;

  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign v_d = carry[WIDTH] ^ carry[WIDTH-1];
  assign z_d = (sum == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      v_q <= v_d;
      z_q <= z_d;
    end
  end

  assign V = v_q;
  assign Z = z_q;
`endif

endmodule : add_sub_4_bit

`default_nettype wire

// File: tb/tb_add_sub_4_bit.sv
// ============================================================================
// Module      : tb_add_sub_4_bit
// Description : Directed and exhaustive checks of add_sub_4_bit, both builds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_sub_4_bit;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       m;
  logic [3:0] s;
  logic       c;
`ifdef ADD_SUB_4_BIT_FLAGS_EN
  logic       v;
  logic       z;
`endif

  int n_checks;
  int n_errors;

  add_sub_4_bit #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .M   (m),
    .S   (s),
    .C   (c)
`ifdef ADD_SUB_4_BIT_FLAGS_EN
    ,
    .V   (v),
    .Z   (z)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs, clock one edge, leave time for the registers to settle.
  task automatic step(input logic r, input logic [3:0] ai, input logic [3:0] bi, input logic mi);
    rst = r;
    a   = ai;
    b   = bi;
    m   = mi;
    @(posedge clk);
    #1;
  endtask

  // Outputs expected for the most recently applied operation.
  task automatic check_all(input string tag, input logic [3:0] es, input logic ec,
                           input logic ev, input logic ez);
    check({tag, ".S"}, {4'h0, s}, {4'h0, es});
    check({tag, ".C"}, {7'h0, c}, {7'h0, ec});
`ifdef ADD_SUB_4_BIT_FLAGS_EN
    check({tag, ".V"}, {7'h0, v}, {7'h0, ev});
    check({tag, ".Z"}, {7'h0, z}, {7'h0, ez});
`endif
  endtask

  // Reference model in arithmetic terms: unsigned carry / no-borrow, signed overflow.
  task automatic model(input logic [3:0] ai, input logic [3:0] bi, input logic mi,
                       output logic [3:0] es, output logic ec, output logic ev, output logic ez);
    logic [4:0] t;
    if (!mi) begin
      t  = {1'b0, ai} + {1'b0, bi};
      es = t[3:0];
      ec = t[4];
      ev = (ai[3] == bi[3]) && (es[3] != ai[3]);
    end else begin
      es = ai - bi;
      ec = (ai >= bi);
      ev = (ai[3] != bi[3]) && (es[3] != ai[3]);
    end
    ez = (es == 4'h0);
  endtask

  initial begin
    logic [3:0] es;
    logic       ec, ev, ez;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    a   = 4'h0;
    b   = 4'h0;
    m   = 1'b0;

    step(1'b1, 4'hF, 4'hF, 1'b0);
    check_all("reset", 4'h0, 1'b0, 1'b0, 1'b0);

    // First edge after release reflects the inputs sampled there.
    step(1'b0, 4'hA, 4'h5, 1'b0);
    check_all("add_A_5", 4'hF, 1'b0, 1'b0, 1'b0);

    // Between edges the outputs hold even when inputs move.
    a = 4'h0;
    b = 4'h0;
    #3;
    check("hold.S", {4'h0, s}, 8'h0F);

    step(1'b0, 4'hA, 4'h5, 1'b1);
    check_all("sub_A_5", 4'h5, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'hA, 4'h3, 1'b1);
    check_all("sub_A_3", 4'h7, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'h3, 4'h5, 1'b1);
    check_all("sub_3_5", 4'hE, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h8, 4'h8, 1'b0);
    check_all("add_8_8", 4'h0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 4'h7, 4'h1, 1'b0);
    check_all("add_7_1", 4'h8, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 4'h8, 1'b1);
    check_all("sub_0_8", 4'h8, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h6, 4'h6, 1'b1);
    check_all("sub_6_6", 4'h0, 1'b1, 1'b0, 1'b1);

    // Reset mid-stream wins over a live operation, then operation resumes.
    step(1'b1, 4'hF, 4'h1, 1'b0);
    check_all("reset_mid", 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'hF, 4'h1, 1'b0);
    check_all("after_rst", 4'h0, 1'b1, 1'b0, 1'b1);

    for (int mi = 0; mi < 2; mi++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          step(1'b0, 4'(ai), 4'(bi), 1'(mi));
          model(4'(ai), 4'(bi), 1'(mi), es, ec, ev, ez);
          check_all($sformatf("sweep_m%0d_a%0h_b%0h", mi, ai, bi), es, ec, ev, ez);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_add_sub_4_bit

`default_nettype wire
